// File: rtl/spi_req_arbiter_if.sv
// Bundle between the requesters, the arbiter and the shared SPI master engine.
// slave: the arbiter's view. master: the requester/engine side.
interface spi_req_arbiter_if #(
   parameter int unsigned N_REQ  = 4,
   parameter int unsigned DATA_W = 64,
   parameter int unsigned LEN_W  = 3,
   parameter int unsigned RX_W   = 8
);
   // Requester side
   logic [N_REQ-1:0]        req;
   logic [N_REQ*DATA_W-1:0] req_data;
   logic [N_REQ*LEN_W-1:0]  req_len;
   logic [N_REQ-1:0]        gnt;
   logic [N_REQ-1:0]        done;
   logic [RX_W-1:0]         rx_data;
   logic                    timeout_err;
   logic                    arb_busy;

   // Engine side
   logic                    spi_start;
   logic [DATA_W-1:0]       spi_data;
   logic [LEN_W-1:0]        spi_bite_num;
   logic                    spi_busy;
   logic                    spi_finished;
   logic [RX_W-1:0]         spi_data_out;

   modport slave (
      input  req, req_data, req_len, spi_busy, spi_finished, spi_data_out,
      output gnt, done, rx_data, timeout_err, arb_busy, spi_start, spi_data, spi_bite_num
   );

   modport master (
      output req, req_data, req_len, spi_busy, spi_finished, spi_data_out,
      input  gnt, done, rx_data, timeout_err, arb_busy, spi_start, spi_data, spi_bite_num
   );
endinterface

// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter/sequencer sharing one SPI master engine between N_REQ
// requesters. Latches the winner's command, pulses spi_start, waits for the
// engine to finish and returns the received byte with a per-requester done.
// Optional watchdog abort: define SPI_TIMEOUT_EN.
module spi_req_arbiter #(
   parameter int unsigned N_REQ  = 4,
   parameter int unsigned DATA_W = 64,
   parameter int unsigned LEN_W  = 3,
   parameter int unsigned RX_W   = 8
`ifdef SPI_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT_CYC = 4096
`endif
) (
   input logic              clk,
   input logic              rst,
   spi_req_arbiter_if.slave bus
);

   localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_BUSY = 2'd1,
      ST_WAIT_DONE = 2'd2
   } state_t;

   state_t             state;
   logic [IDX_W-1:0]   ptr;
   logic [IDX_W-1:0]   win_idx;
   logic [N_REQ-1:0]   gnt_q;
   logic [N_REQ-1:0]   done_q;
   logic [RX_W-1:0]    rx_q;
   logic               busy_q;
   logic               start_q;
   logic [DATA_W-1:0]  data_q;
   logic [LEN_W-1:0]   len_q;

   logic               pick_found_c;
   logic [IDX_W-1:0]   pick_idx_c;
   logic [IDX_W-1:0]   ptr_next_c;
   logic [DATA_W-1:0]  pick_data_c;
   logic [LEN_W-1:0]   pick_len_c;

`ifdef SPI_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0]   cnt_q;
   logic               to_q;
`endif

   // First requesting index at or above the pointer, wrapping; scanning from
   // the far end lets the closest candidate overwrite the others.
   always_comb begin
      logic [IDX_W:0] cand;
      pick_found_c = 1'b0;
      pick_idx_c   = '0;
      cand         = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         cand = {1'b0, ptr} + (IDX_W+1)'(k);
         if (cand >= (IDX_W+1)'(N_REQ)) begin
            cand = cand - (IDX_W+1)'(N_REQ);
         end
         if (bus.req[cand[IDX_W-1:0]]) begin
            pick_found_c = 1'b1;
            pick_idx_c   = cand[IDX_W-1:0];
         end
      end
   end

   // Winner's command fields and the pointer value after granting it.
   always_comb begin
      pick_data_c = bus.req_data[int'(pick_idx_c) * DATA_W +: DATA_W];
      pick_len_c  = bus.req_len[int'(pick_idx_c) * LEN_W +: LEN_W];
      ptr_next_c  = (pick_idx_c == IDX_W'(N_REQ - 1)) ? '0 : pick_idx_c + IDX_W'(1);
   end

   // Sequencer: grant, wait for the engine, report completion.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         ptr     <= '0;
         win_idx <= '0;
         gnt_q   <= '0;
         done_q  <= '0;
         rx_q    <= '0;
         busy_q  <= 1'b0;
         start_q <= 1'b0;
         data_q  <= '0;
         len_q   <= '0;
`ifdef SPI_TIMEOUT_EN
         cnt_q   <= '0;
         to_q    <= 1'b0;
`endif
      end else begin
         gnt_q   <= '0;
         done_q  <= '0;
         start_q <= 1'b0;
`ifdef SPI_TIMEOUT_EN
         to_q    <= 1'b0;
`endif
         case (state)
            ST_IDLE: begin
               // spi_finished is deliberately ignored here
               if (pick_found_c) begin
                  win_idx <= pick_idx_c;
                  data_q  <= pick_data_c;
                  len_q   <= pick_len_c;
                  gnt_q   <= N_REQ'(1) << pick_idx_c;
                  start_q <= 1'b1;
                  busy_q  <= 1'b1;
                  ptr     <= ptr_next_c;
                  state   <= ST_WAIT_BUSY;
`ifdef SPI_TIMEOUT_EN
                  cnt_q   <= '0;
`endif
               end
            end
            ST_WAIT_BUSY, ST_WAIT_DONE: begin
               // A finish pulse completes the transfer even if busy was never seen
               if (bus.spi_finished) begin
                  rx_q   <= bus.spi_data_out;
                  done_q <= N_REQ'(1) << win_idx;
                  busy_q <= 1'b0;
                  state  <= ST_IDLE;
               end
`ifdef SPI_TIMEOUT_EN
               else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                  rx_q   <= '0;
                  done_q <= N_REQ'(1) << win_idx;
                  to_q   <= 1'b1;
                  busy_q <= 1'b0;
                  state  <= ST_IDLE;
               end
`endif
               else if (state == ST_WAIT_BUSY && bus.spi_busy) begin
                  state <= ST_WAIT_DONE;
               end
`ifdef SPI_TIMEOUT_EN
               cnt_q <= cnt_q + CNT_W'(1);
`endif
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.gnt          = gnt_q;
   assign bus.done         = done_q;
   assign bus.rx_data      = rx_q;
   assign bus.arb_busy     = busy_q;
   assign bus.spi_start    = start_q;
   assign bus.spi_data     = data_q;
   assign bus.spi_bite_num = len_q;
`ifdef SPI_TIMEOUT_EN
   assign bus.timeout_err  = to_q;
`else
   assign bus.timeout_err  = 1'b0;
`endif

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Directed bench for spi_req_arbiter with a behavioural SPI engine and a
// grant/done scoreboard. Define SPI_TIMEOUT_EN to include the watchdog case.
module tb_spi_req_arbiter;
   localparam int unsigned N_REQ  = 4;
   localparam int unsigned DATA_W = 64;
   localparam int unsigned LEN_W  = 3;
   localparam int unsigned RX_W   = 8;
`ifdef SPI_TIMEOUT_EN
   localparam int unsigned TIMEOUT_CYC = 16;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   spi_req_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W), .LEN_W(LEN_W), .RX_W(RX_W)) bus ();

   spi_req_arbiter #(
      .N_REQ(N_REQ), .DATA_W(DATA_W), .LEN_W(LEN_W), .RX_W(RX_W)
`ifdef SPI_TIMEOUT_EN
      , .TIMEOUT_CYC(TIMEOUT_CYC)
`endif
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      int              idx;
      logic [RX_W-1:0] rx;
      bit              to;
   } exp_done_t;

   typedef enum {M_NORMAL, M_COINC, M_HANG} eng_mode_t;

   int        n_checks = 0;
   int        n_err    = 0;
   int        cyc      = 0;
   int        n_gnt    = 0;
   int        n_done   = 0;
   int        last_gnt_cyc = 0;
   logic      prev_arb_busy = 1'b0;
   int        exp_gnt_q [$];
   exp_done_t exp_done_q [$];

   logic [DATA_W-1:0] td [N_REQ];
   logic [LEN_W-1:0]  tl [N_REQ];

   eng_mode_t       eng_mode = M_NORMAL;
   int              eng_busy_cyc = 3;
   logic [RX_W-1:0] eng_rx_base = 8'h3C;
   int              stray_cnt = 0;
   int              eng_starts;
   int              fin_cyc;
   int              stray_seen;

   int fair_order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [N_REQ-1:0] oh(input int i);
      logic [N_REQ-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   task automatic expect_xfer(input int idx, input logic [RX_W-1:0] rx, input bit to);
      exp_done_t d;
      d.idx = idx;
      d.rx  = rx;
      d.to  = to;
      exp_gnt_q.push_back(idx);
      exp_done_q.push_back(d);
   endtask

   task automatic apply_data();
      for (int i = 0; i < N_REQ; i++) begin
         bus.req_data[i*DATA_W +: DATA_W] = td[i];
         bus.req_len[i*LEN_W +: LEN_W]    = tl[i];
      end
   endtask

   // One clock step; outputs sampled 1 time unit after the edge and scored.
   task automatic tick();
      exp_done_t d;
      int e;
      @(posedge clk);
      cyc++;
      #1;
      if (!rst) begin
         if (bus.spi_start === 1'b1) begin
            chk("start_not_busy", 64'(prev_arb_busy), 64'(0));
            chk("start_has_gnt", 64'(|bus.gnt), 64'(1));
         end
         if (bus.gnt !== '0) begin
            n_gnt++;
            last_gnt_cyc = cyc;
            chk("gnt_done_excl", 64'(bus.gnt & bus.done), 64'(0));
            if (exp_gnt_q.size() == 0) begin
               chk("gnt_unexpected", 64'(bus.gnt), 64'(0));
            end else begin
               e = exp_gnt_q.pop_front();
               chk("gnt_order", 64'(bus.gnt), 64'(oh(e)));
               chk("gnt_spi_data", bus.spi_data, td[e]);
               chk("gnt_spi_len", 64'(bus.spi_bite_num), 64'(tl[e]));
               chk("gnt_arb_busy", 64'(bus.arb_busy), 64'(1));
            end
         end
         if (bus.done !== '0) begin
            n_done++;
            if (exp_done_q.size() == 0) begin
               chk("done_unexpected", 64'(bus.done), 64'(0));
            end else begin
               d = exp_done_q.pop_front();
               chk("done_idx", 64'(bus.done), 64'(oh(d.idx)));
               chk("done_rx", 64'(bus.rx_data), 64'(d.rx));
               chk("done_timeout_err", 64'(bus.timeout_err), 64'(d.to));
               chk("done_arb_busy", 64'(bus.arb_busy), 64'(0));
               chk("done_spi_data_hold", bus.spi_data, td[d.idx]);
`ifdef SPI_TIMEOUT_EN
               if (d.to) chk("done_timeout_lat", 64'(cyc - last_gnt_cyc), 64'(TIMEOUT_CYC));
               else      chk("done_latency", 64'(cyc), 64'(fin_cyc + 1));
`else
               chk("done_latency", 64'(cyc), 64'(fin_cyc + 1));
`endif
            end
         end
      end
      prev_arb_busy = bus.arb_busy;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while ((exp_done_q.size() != 0 || bus.arb_busy !== 1'b0) && n < 400) begin
         tick();
         n++;
      end
      chk({tag, "_drain"}, 64'(exp_done_q.size()), 64'(0));
      chk({tag, "_idle"}, 64'(bus.arb_busy), 64'(0));
   endtask

   task automatic run_grants(input logic [N_REQ-1:0] r, input int cnt, input string tag);
      int target = n_gnt + cnt;
      int n = 0;
      bus.req = r;
      while (n_gnt < target && n < 500) begin
         tick();
         n++;
      end
      bus.req = '0;
      chk({tag, "_gnt_count"}, 64'(n_gnt), 64'(target));
      wait_idle(tag);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_gnt"}, 64'(bus.gnt), 64'(0));
      chk({tag, "_done"}, 64'(bus.done), 64'(0));
      chk({tag, "_spi_start"}, 64'(bus.spi_start), 64'(0));
      chk({tag, "_arb_busy"}, 64'(bus.arb_busy), 64'(0));
      chk({tag, "_timeout_err"}, 64'(bus.timeout_err), 64'(0));
      chk({tag, "_rx_data"}, 64'(bus.rx_data), 64'(0));
      chk({tag, "_spi_data"}, bus.spi_data, 64'(0));
      chk({tag, "_spi_bite_num"}, 64'(bus.spi_bite_num), 64'(0));
   endtask

   task automatic eng_step();
      @(posedge clk);
      #1;
   endtask

   // Behavioural SPI engine: reacts to spi_start according to eng_mode.
   initial begin
      logic [RX_W-1:0] rx;
      int i;
      bit aborted;
      eng_starts = 0;
      fin_cyc    = 0;
      stray_seen = 0;
      bus.spi_busy     = 1'b0;
      bus.spi_finished = 1'b0;
      bus.spi_data_out = '0;
      forever begin
         eng_step();
         if (rst) begin
            bus.spi_busy     = 1'b0;
            bus.spi_finished = 1'b0;
         end else if (bus.spi_start === 1'b1) begin
            eng_starts++;
            rx = eng_rx_base ^ bus.spi_data[7:0];
            eng_step();
            case (eng_mode)
               M_NORMAL: begin
                  bus.spi_busy = 1'b1;
                  i = 0;
                  aborted = 1'b0;
                  while (i < eng_busy_cyc && !aborted) begin
                     eng_step();
                     if (rst) aborted = 1'b1;
                     i++;
                  end
                  bus.spi_busy = 1'b0;
                  if (!aborted) begin
                     bus.spi_finished = 1'b1;
                     bus.spi_data_out = rx;
                     fin_cyc = cyc;
                     eng_step();
                     bus.spi_finished = 1'b0;
                  end
               end
               M_COINC: begin
                  bus.spi_busy     = 1'b1;
                  bus.spi_finished = 1'b1;
                  bus.spi_data_out = rx;
                  fin_cyc = cyc;
                  eng_step();
                  bus.spi_busy     = 1'b0;
                  bus.spi_finished = 1'b0;
               end
               default: begin
                  bus.spi_busy = 1'b1;
                  i = 0;
                  while (bus.arb_busy === 1'b1 && !rst && i < 10000) begin
                     eng_step();
                     i++;
                  end
                  bus.spi_busy = 1'b0;
               end
            endcase
         end else if (stray_seen != stray_cnt) begin
            bus.spi_finished = 1'b1;
            bus.spi_data_out = 8'hFF;
            eng_step();
            bus.spi_finished = 1'b0;
            stray_seen = stray_cnt;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int starts0;
      int done0;
      rst          = 1'b1;
      bus.req      = '0;
      bus.req_data = '0;
      bus.req_len  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         td[i] = 64'h0123_4567_89AB_CD00 | 64'(i * 17);
         tl[i] = LEN_W'(i + 2);
      end
      td[1] = 64'hA5A5_0000_0000_0000;
      tl[1] = 3'd0;
      apply_data();

      // Reset values
      repeat (3) tick();
      chk_all_zero("reset");
      rst = 1'b0;
      tick();

      // Single request: low byte of td[1] is 00, so the engine returns 3C
      bus.req = 4'b0010;
      expect_xfer(1, 8'h3C, 1'b0);
      tick();
      chk("single_gnt", 64'(bus.gnt), 64'(4'b0010));
      chk("single_start", 64'(bus.spi_start), 64'(1));
      chk("single_spi_data", bus.spi_data, 64'hA5A5_0000_0000_0000);
      chk("single_len", 64'(bus.spi_bite_num), 64'(0));
      bus.req = '0;
      wait_idle("single");
      chk("single_rx_hold", 64'(bus.rx_data), 64'(8'h3C));

      // Fairness from a fresh reset: all four requesting
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      tick();
      eng_rx_base  = 8'h5A;
      eng_busy_cyc = 2;
      starts0 = eng_starts;
      for (int k = 0; k < 8; k++) expect_xfer(fair_order[k], 8'h5A ^ td[fair_order[k]][7:0], 1'b0);
      run_grants(4'b1111, 8, "fair");
      chk("fair_starts", 64'(eng_starts - starts0), 64'(8));

      // Pointer wrap and skip after a grant to 3
      expect_xfer(0, 8'h5A ^ td[0][7:0], 1'b0);
      expect_xfer(2, 8'h5A ^ td[2][7:0], 1'b0);
      run_grants(4'b0101, 2, "wrap");

      // Busy and finished in the same cycle
      eng_mode = M_COINC;
      done0 = n_done;
      expect_xfer(3, 8'h5A ^ td[3][7:0], 1'b0);
      run_grants(4'b1000, 1, "coinc");
      repeat (4) tick();
      chk("coinc_single_done", 64'(n_done - done0), 64'(1));
      chk("coinc_arb_busy", 64'(bus.arb_busy), 64'(0));

      // Finished while idle is ignored
      eng_mode = M_NORMAL;
      done0 = n_done;
      stray_cnt++;
      repeat (4) tick();
      chk("stray_no_done", 64'(n_done - done0), 64'(0));
      chk("stray_rx_hold", 64'(bus.rx_data), 64'(8'h5A ^ td[3][7:0]));

      // Reset during WAIT_DONE
      eng_busy_cyc = 30;
      expect_xfer(1, 8'h5A ^ td[1][7:0], 1'b0);
      bus.req = 4'b0010;
      tick();
      bus.req = '0;
      repeat (4) tick();
      chk("mid_arb_busy", 64'(bus.arb_busy), 64'(1));
      rst = 1'b1;
      exp_done_q.delete();
      tick();
      chk_all_zero("rst_mid");
      tick();
      rst = 1'b0;
      tick();
      eng_busy_cyc = 2;
      // Pointer back at 0: 1 wins over 3
      expect_xfer(1, 8'h5A ^ td[1][7:0], 1'b0);
      run_grants(4'b1010, 1, "post_rst_a");
      expect_xfer(3, 8'h5A ^ td[3][7:0], 1'b0);
      run_grants(4'b1000, 1, "post_rst_b");

`ifdef SPI_TIMEOUT_EN
      // Engine never finishes: watchdog abort, then normal service resumes
      eng_mode = M_HANG;
      expect_xfer(2, 8'h00, 1'b1);
      run_grants(4'b0100, 1, "tmo");
      chk("tmo_rx_zero", 64'(bus.rx_data), 64'(0));
      eng_mode = M_NORMAL;
      expect_xfer(0, 8'h5A ^ td[0][7:0], 1'b0);
      run_grants(4'b0101, 1, "tmo_next");
`endif

      repeat (3) tick();
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
